// File: rtl/pe_alu_pkg.sv
// Shared types for the multi-cycle PE ALU.
// Holds the opcode encoding and the controller state type.
package pe_alu_pkg;

  typedef enum logic [4:0] {
    OpAdd   = 5'b00000,
    OpSub   = 5'b00001,
    OpMul   = 5'b00010,
    OpDivu  = 5'b00011,
    OpSll   = 5'b00100,
    OpSrl   = 5'b00101,
    OpRol   = 5'b00110,
    OpRor   = 5'b00111,
    OpAnd   = 5'b01000,
    OpOr    = 5'b01001,
    OpXor   = 5'b01010,
    OpNor   = 5'b01011,
    OpNand  = 5'b01100,
    OpSltu  = 5'b01101,
    OpSlt   = 5'b01110,
    OpSra   = 5'b01111,
    OpSextb = 5'b10000,
    OpSexth = 5'b10001,
    OpZextb = 5'b10010,
    OpZexth = 5'b10011,
    OpRemu  = 5'b10100
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/pe_alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              load dividend/divisor and begin (ignored while running)
//   dividend, divisor  operands, sampled on start
//   done               high during the cycle whose edge completes the last iteration
//   quotient, remainder  values produced by that iteration (valid while done=1)
module pe_alu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]   rem_q, rem_nxt, rem_sh, diff;
  logic [WIDTH-1:0] quo_q, quo_nxt, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  // Shift in the next dividend bit; keep the subtraction only if it did not borrow.
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_nxt = diff;
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh;
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Results are presented combinationally so the owner can register them on the final edge.
  assign done      = run_q && (cnt_q == CW'(1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start && !run_q) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH);
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_alu_mc.sv
// Multi-cycle PE ALU: single-cycle arithmetic/logic ops plus an iterative divider,
// with valid/ready handshakes on input and output. One operation in flight at a time.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operation handshake (in_ready only in idle)
//   op, a, b                   opcode and operands, captured at accept
//   out_valid/out_ready        result handshake
//   result, zero, div_by_zero  registered result and flags, stable while out_valid
//   busy                       controller not idle
module pe_alu_mc
  import pe_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned HW  = (WIDTH >= 16) ? 16 : WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, dbz_q, dbz_d;
  logic             rem_sel_q, rem_sel_d;

  op_e              op_sel;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu;
  logic             accept, is_div, b_zero, div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign op_sel    = op_e'(op);
  assign sh        = b[SHW-1:0];
  assign accept    = in_valid && (state_q == StIdle);
  assign is_div    = (op_sel == OpDivu) || (op_sel == OpRemu);
  assign b_zero    = (b == '0);
  assign div_start = accept && is_div && !b_zero;

  always_comb begin
    alu = a + b;
    unique case (op_sel)
      OpSub:   alu = a - b;
      OpMul:   alu = a * b;
      OpSll:   alu = a << sh;
      OpSrl:   alu = a >> sh;
      // Shift by WIDTH yields zero, so sh=0 leaves a unchanged.
      OpRol:   alu = (a << sh) | (a >> (WIDTH - 32'(sh)));
      OpRor:   alu = (a >> sh) | (a << (WIDTH - 32'(sh)));
      OpAnd:   alu = a & b;
      OpOr:    alu = a | b;
      OpXor:   alu = a ^ b;
      OpNor:   alu = ~(a | b);
      OpNand:  alu = ~(a & b);
      OpSltu:  alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OpSlt:   alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSra:   alu = $signed(a) >>> sh;
      // Sign-extend by moving the field to the top and shifting back arithmetically.
      OpSextb: alu = $signed(a << (WIDTH - 8)) >>> (WIDTH - 8);
      OpSexth: alu = $signed(a << (WIDTH - HW)) >>> (WIDTH - HW);
      OpZextb: alu = a & ({WIDTH{1'b1}} >> (WIDTH - 8));
      OpZexth: alu = a & ({WIDTH{1'b1}} >> (WIDTH - HW));
      // Divide by zero is resolved in one cycle.
      OpDivu:  alu = '1;
      OpRemu:  alu = a;
      default: alu = a + b;
    endcase
  end

  pe_alu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    rem_sel_d = rem_sel_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_div && !b_zero) begin
            state_d   = StDiv;
            rem_sel_d = (op_sel == OpRemu);
          end else begin
            state_d  = StDone;
            result_d = alu;
            zero_d   = (alu == '0);
            dbz_d    = is_div;
          end
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d  = StDone;
          result_d = rem_sel_q ? div_rem : div_quo;
          zero_d   = (result_d == '0);
          dbz_d    = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_pe_alu_mc.sv
module tb_pe_alu_mc;
  import pe_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, zero, div_by_zero, busy;
  logic [31:0] result;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [4:0]  op16 = 5'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, zero16, dbz16, busy16;
  logic [15:0] result16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_alu_mc #(.WIDTH(32), .OPW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .div_by_zero(div_by_zero), .busy(busy)
  );

  pe_alu_mc #(.WIDTH(16), .OPW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .zero(zero16), .div_by_zero(dbz16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op on the 32-bit instance, wait for out_valid, capture, then complete the handshake.
  // extra = edges after the accept edge before out_valid was seen.
  task automatic run_op(input op_e o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic z, output logic dbz,
                        output int extra);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 in_valid = 1'b0; a = 32'h5A5A_5A5A; b = 32'h0; op = OpXor;
    extra = 0;
    @(negedge clk);
    while (!out_valid && extra < 100) begin
      @(posedge clk);
      extra++;
      @(negedge clk);
    end
    res = result; z = zero; dbz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        z, d;
  int          ex;

  initial begin
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero_dbz_busy", {29'd0, zero, div_by_zero, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(OpAdd, 32'hFFFF_FFFF, 32'd1, r, z, d, ex);
    chk("add_res", r, 32'd0);
    chk("add_zero", 32'(z), 32'd1);
    chk("add_lat", 32'(ex), 32'd0);

    run_op(OpSlt, 32'h8000_0000, 32'd1, r, z, d, ex);
    chk("slt", r, 32'd1);
    chk("slt_zero", 32'(z), 32'd0);
    run_op(OpSltu, 32'h8000_0000, 32'd1, r, z, d, ex);
    chk("sltu", r, 32'd0);
    chk("sltu_zero", 32'(z), 32'd1);
    run_op(OpSra, 32'h8000_0010, 32'd4, r, z, d, ex);
    chk("sra", r, 32'hF800_0001);
    run_op(OpRol, 32'h8000_0001, 32'd1, r, z, d, ex);
    chk("rol", r, 32'h0000_0003);
    run_op(OpRor, 32'h8000_0001, 32'd1, r, z, d, ex);
    chk("ror", r, 32'hC000_0000);
    run_op(OpSll, 32'd1, 32'h21, r, z, d, ex);
    chk("sll_mask", r, 32'd2);
    run_op(OpSrl, 32'h1234_5678, 32'd0, r, z, d, ex);
    chk("srl_by0", r, 32'h1234_5678);
    run_op(OpSextb, 32'h0000_1280, 32'd0, r, z, d, ex);
    chk("sextb", r, 32'hFFFF_FF80);
    run_op(OpZexth, 32'hABCD_8765, 32'd0, r, z, d, ex);
    chk("zexth", r, 32'h0000_8765);
    run_op(OpNor, 32'h0F0F_0000, 32'h0000_00F0, r, z, d, ex);
    chk("nor", r, 32'hF0F0_FF0F);
    run_op(OpMul, 32'h0001_0001, 32'h0001_0003, r, z, d, ex);
    chk("mul_low", r, 32'h0004_0003);
    run_op(op_e'(5'b11111), 32'd20, 32'd22, r, z, d, ex);
    chk("unlisted_add", r, 32'd42);

    run_op(OpDivu, 32'd100, 32'd7, r, z, d, ex);
    chk("divu_res", r, 32'd14);
    chk("divu_lat", 32'(ex), 32'd32);
    chk("divu_dbz", 32'(d), 32'd0);
    run_op(OpRemu, 32'd100, 32'd7, r, z, d, ex);
    chk("remu_res", r, 32'd2);
    chk("remu_dbz", 32'(d), 32'd0);
    run_op(OpDivu, 32'hFFFF_FFFF, 32'd1, r, z, d, ex);
    chk("divu_by1", r, 32'hFFFF_FFFF);
    run_op(OpRemu, 32'd21, 32'd7, r, z, d, ex);
    chk("remu_zero_flag", {r[30:0], z}, 32'd1);

    run_op(OpDivu, 32'd5, 32'd0, r, z, d, ex);
    chk("dbz_divu_res", r, 32'hFFFF_FFFF);
    chk("dbz_divu_flag", 32'(d), 32'd1);
    chk("dbz_divu_lat", 32'(ex), 32'd0);
    run_op(OpRemu, 32'd5, 32'd0, r, z, d, ex);
    chk("dbz_remu_res", r, 32'd5);
    chk("dbz_remu_flag", 32'(d), 32'd1);

    // Backpressure: result holds, new offers ignored.
    @(negedge clk);
    in_valid = 1'b1; op = OpSub; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1 op = OpAdd; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {result[28:0], zero, out_valid, in_ready}, 32'b110);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1; op = OpDivu; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {28'd0, in_ready, out_valid, busy, div_by_zero}, 32'b1000);
    chk("midrst_res", {result[30:0], zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midrst_after", {30'd0, in_ready, out_valid}, 32'b10);

    // 16-bit instance divide.
    @(negedge clk);
    in_valid16 = 1'b1; op16 = OpDivu; a16 = 16'hFFFF; b16 = 16'h0010;
    @(posedge clk);
    #1 in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    ex = 0;
    @(negedge clk);
    while (!out_valid16 && ex < 100) begin
      @(posedge clk);
      ex++;
      @(negedge clk);
    end
    chk("div16_res", 32'(result16), 32'h0000_0FFF);
    chk("div16_lat", 32'(ex), 32'd16);
    chk("div16_dbz", 32'(dbz16), 32'd0);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
    @(negedge clk);
    chk("div16_idle", {30'd0, in_ready16, busy16}, 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_alu_mc.md
Name: pe_alu_mc

Overview:
- Parametrised multi-cycle ALU for the RISC-V PE / CGRA datapath.
- Generalises the PE ALU in several ways:
  - WIDTH-bit operands.
  - Shift and rotate amount taken from B.
  - Iterative restoring divider with remainder.
  - valid/ready handshakes on both sides.
  - Zero flag computed on the result being issued.
- Sits between the PE decode/operand stage and writeback; holds one operation at a time.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0] (derived, not overridden).
- OPW, 5, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; =1 only in IDLE.
- op  in  OPW  opcode, see package.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0; same cycle as result.
- div_by_zero  out  1  DIVU/REMU with b==0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - Outputs: in_ready=1, out_valid=0, result=0, zero=0, div_by_zero=0, busy=0.
  - Any in-flight divide is discarded.
- States and transitions:
  - IDLE: accept on in_valid&&in_ready. Divide opcode with b!=0 goes to DIV; every other opcode goes to DONE.
  - DIV: runs WIDTH iterations, then goes to DONE.
  - DONE: out_valid=1. Moves to IDLE on out_ready. Result, zero and div_by_zero hold stable while out_ready=0.
- Latency (accept edge = k):
  - Single-cycle ops: out_valid=1 after edge k.
  - DIVU/REMU with b!=0: out_valid=1 after edge k+WIDTH.
  - Divide by zero: out_valid=1 after edge k.
- Throughput: no overlap. in_ready=0 in DIV and DONE, so the next accept is at the earliest on the edge after the out_ready handshake.
- Opcodes (unlisted codes give ADD):
  - ADD, SUB, MUL: low WIDTH bits of the product.
  - SLL, SRL.
  - ROL, ROR: by b[SHW-1:0].
  - AND, OR, XOR, NOR, NAND.
  - SLTU (unsigned), SLT (two's-complement). Both produce 1 or 0, zero-extended.
  - SRA by b[SHW-1:0]: single-cycle barrel shift with sign fill.
  - SEXTB, SEXTH, ZEXTB, ZEXTH.
  - DIVU, REMU.
- Shift/rotate amount: upper bits of b are ignored. A shift of 0 returns a unchanged.
- Divider:
  - Restoring, one quotient bit per cycle, MSB first.
  - Internal registers: WIDTH-bit quotient, WIDTH+1-bit partial remainder.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero:
  - result = all ones for DIVU, result = a for REMU.
  - div_by_zero=1; no DIV state entered.
  - div_by_zero=0 for every other case.
- Flags:
  - zero is computed from the new result in the same cycle it is loaded, never from the prior value.
  - No simulation-only prints in synthesised paths.
- Operands and op are captured at accept; later changes on a, b or op have no effect.
- in_valid while in_ready=0 is ignored, not queued.

Decomposition:
- Shared package pe_alu_pkg holds:
  - The op encoding as a typedef enum, 5 bits: ADD=00000, SUB=00001, MUL=00010, DIVU=00011, SLL=00100, SRL=00101, ROL=00110, ROR=00111, AND=01000, OR=01001, XOR=01010, NOR=01011, NAND=01100, SLTU=01101, SLT=01110, SRA=01111, SEXTB=10000, SEXTH=10001, ZEXTB=10010, ZEXTH=10011, REMU=10100.
  - The FSM state typedef.
- One sub-module: pe_alu_divider (start, dividend, divisor → done, quotient, remainder; iterative, WIDTH cycles).
  - The top holds the combinational single-cycle ops, the FSM and the output registers.

Test Plan:
- Reset mid-divide: accept DIVU a=100, b=7; pull rst_n low at cycle 5 → outputs go to reset values immediately; after release, in_ready=1 and no stale out_valid.
- Single-cycle ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → result 0, zero=1 after 1 cycle.
  - SLT 0x80000000 vs 1 → 1.
  - SLTU of the same operands → 0.
  - SRA 0x80000010 by 4 → 0xF8000001.
  - ROL 0x80000001 by 1 → 0x00000003.
- Shift masking: SLL a=1, b=0x21 → result 2 (only b[4:0] used).
- Divide: DIVU 100/7 → 14 after exactly 32 cycles; REMU 100/7 → 2; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; div_by_zero=0 throughout.
- Divide by zero: DIVU a=5, b=0 → 0xFFFFFFFF, div_by_zero=1, 1-cycle latency; REMU a=5, b=0 → 5.
- Backpressure: hold out_ready=0 for 10 cycles after SUB 3-3 → result 0 and zero=1 stable, in_ready=0, new in_valid ignored; out_ready=1 → IDLE next cycle. Repeat with WIDTH=16: DIVU 0xFFFF/0x10 → 0x0FFF after 16 cycles.
